mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port, fixed-latency unified memory between the instruction-fetch requester and the data-memory (MEM stage) requester of the 5-stage pipeline.
- Registers one request at a time, drives the memory port, counts out the latency and returns read data with a one-cycle done pulse.
- Generates the stall terms that gate the enables of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

Parameters:
- MEM_LAT, 4, memory read latency in cycles, measured from the mem_en cycle to the mem_rdata-valid cycle; legal range is at least 1.
- CNT_W, 3, latency counter width; must satisfy 2^CNT_W > MEM_LAT.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-low reset (rst=0 resets on the next rising edge)
- if_req  in  1  fetch request; held high until if_done
- if_addr  in  16  fetch address
- if_rdata  out  16  fetched instruction; registered
- if_done  out  1  one-cycle completion pulse for fetch
- dm_req  in  1  data request; held high until dm_done
- dm_wr  in  1  1 = store, 0 = load
- dm_addr  in  16  data address
- dm_wdata  in  16  store data
- dm_rdata  out  16  load data; registered
- dm_done  out  1  one-cycle completion pulse for data
- mem_en  out  1  memory access strobe; high exactly one cycle per access
- mem_wr  out  1  write strobe qualifier
- mem_addr  out  16  memory address; held for the whole access
- mem_wdata  out  16  memory write data; held for the whole access
- mem_rdata  in  16  memory read data; valid MEM_LAT cycles after mem_en
- stall_if  out  1  if_req & ~if_done; holds PC and IF/ID
- stall_mem  out  1  dm_req & ~dm_done; holds all pipeline registers including EX/MEM
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, WAIT, RESP. All outputs except stall_if, stall_mem and busy are flop outputs.
- Reset (rst=0 at an edge):
  - state=IDLE, mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0.
  - if_done=0, dm_done=0, if_rdata=0, dm_rdata=0, cnt=0, owner=IF, last_grant=IF.
- IDLE:
  - If either request is high, grant one.
  - If both are high, grant the requester other than last_grant. Since last_grant resets to IF, data wins the first tie.
  - On grant, at the edge: latch owner, latch address, write flag and write data (write data from DM only) into mem_addr/mem_wr/mem_wdata; set mem_en=1; load cnt=MEM_LAT; update last_grant; go to WAIT.
- WAIT:
  - mem_en is 1 in the first WAIT cycle only.
  - cnt decrements every cycle.
  - When cnt==0: capture mem_rdata into the owner's rdata register (loads and fetches only; stores leave dm_rdata unchanged), set the owner's done to 1, go to RESP.
- RESP:
  - Owner's done is 1 for exactly this cycle; go to IDLE.
  - No request is accepted in RESP, so a held request is never double-issued.
- Latency: request seen in cycle 0 → mem_en in cycle 1 → mem_rdata valid in cycle 1+MEM_LAT → done in cycle 2+MEM_LAT. The next grant is possible at cycle 3+MEM_LAT at the earliest.
- Dropped request: if the requester deasserts its request mid-access, the access still completes and done still pulses. No cancellation.
- Request changes while busy: the other requester rising mid-access waits. Address or data changes from the owner after grant are ignored, because they were latched at grant.
- Reset mid-operation: return to IDLE on the next edge, with no done pulse and mem_en=0. The memory-side access is abandoned.
- stall_if/stall_mem are combinational from the request and done signals. Pipeline register enable = ~stall_mem (EX/MEM, MEM/WB) and ~(stall_mem|stall_if) (front end).

Decomposition:
- Shared package mem_arb_pkg contains:
  - state encoding IDLE/WAIT/RESP (2 bits)
  - owner encoding OWN_IF=0, OWN_DM=1
  - default MEM_LAT
- Sub-module mem_lat_counter: loadable down-counter with a zero flag.
- The existing dff16/dff1 cells are reused for the address, data and rdata registers.

Test Plan:
- Reset: rst=0 for 2 cycles with both requests high → mem_en=0, both done=0, busy=0, if_rdata=dm_rdata=0. After release, the first grant goes to DM.
- Single fetch: if_req=1, if_addr=0x0010; memory returns 0xABCD in cycle 5 → mem_en=1 only in cycle 1 with mem_addr=0x0010 and mem_wr=0; if_done=1 in cycle 6 with if_rdata=0xABCD; stall_if=1 in cycles 0–5.
- Tie: if_req and dm_req both rise in cycle 0 (load from 0x0200) → DM is granted, dm_done in cycle 6. IF is then granted in cycle 7, mem_en in cycle 8, if_done in cycle 13. stall_mem is low from cycle 6.
- Store: dm_wr=1, dm_addr=0x0100, dm_wdata=0x1234 → mem_wr=1, mem_wdata=0x1234 held through cycles 1–5; dm_done in cycle 6; dm_rdata unchanged.
- Dropped request: if_req deasserted in cycle 3 → if_done still pulses in cycle 6, and no further mem_en occurs.
- Reset mid-access: rst=0 in cycle 3 → cycle 4 is IDLE with no done pulse. After release, a fresh request completes with full 6-cycle latency.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings and defaults for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    localparam int MEM_LAT_DEF = 4;

endpackage

// File: rtl/dff1.sv
// dff1: single-bit enabled register with synchronous active-low reset
module dff1 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk)
        q <= !rst ? 1'b0 : en ? d : q;

endmodule

// File: rtl/dff16.sv
// dff16: 16-bit enabled register with synchronous active-low reset
module dff16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] d,
    output logic [15:0] q
);

    always_ff @(posedge clk)
        q <= !rst ? 16'h0 : en ? d : q;

endmodule

// File: rtl/mem_lat_counter.sv
// mem_lat_counter: loadable down-counter that saturates at zero and flags it
module mem_lat_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk)
        cnt <= !rst ? '0 : load ? load_val : (dec && cnt != '0) ? cnt - 1'b1 : cnt;

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between fetch and data requesters
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF,
    parameter int CNT_W   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_done,
    input  logic        dm_req,
    input  logic        dm_wr,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic [15:0] dm_rdata,
    output logic        dm_done,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        busy
);

    arb_state_t state, state_n;
    logic       grant, gnt_dm, fin, cnt_zero, owner;

    always_ff @(posedge clk)
        state <= !rst ? IDLE : state_n;

    // owner is only rewritten at grant, so it doubles as last_grant for the tie-break
    always_comb begin
        state_n = state;
        grant   = 1'b0;
        gnt_dm  = 1'b0;
        fin     = 1'b0;
        case (state)
            IDLE: begin
                grant   = if_req | dm_req;
                gnt_dm  = dm_req & (~if_req | (owner == OWN_IF));
                state_n = grant ? WAIT : IDLE;
            end
            WAIT: begin
                fin     = cnt_zero;
                state_n = cnt_zero ? RESP : WAIT;
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    mem_lat_counter #(.W(CNT_W)) u_cnt (
        .clk(clk), .rst(rst), .load(grant), .load_val(CNT_W'(MEM_LAT)),
        .dec(state == WAIT), .zero(cnt_zero)
    );

    dff1 u_owner (.clk(clk), .rst(rst), .en(grant), .d(gnt_dm), .q(owner));
    dff1 u_mem_en (.clk(clk), .rst(rst), .en(1'b1), .d(grant), .q(mem_en));
    dff1 u_mem_wr (.clk(clk), .rst(rst), .en(grant), .d(gnt_dm & dm_wr), .q(mem_wr));

    dff16 u_mem_addr (
        .clk(clk), .rst(rst), .en(grant), .d(gnt_dm ? dm_addr : if_addr), .q(mem_addr)
    );
    dff16 u_mem_wdata (
        .clk(clk), .rst(rst), .en(grant), .d(gnt_dm ? dm_wdata : 16'h0), .q(mem_wdata)
    );

    // stores keep the previous load data visible on dm_rdata
    dff16 u_if_rdata (
        .clk(clk), .rst(rst), .en(fin & (owner == OWN_IF)), .d(mem_rdata), .q(if_rdata)
    );
    dff16 u_dm_rdata (
        .clk(clk), .rst(rst), .en(fin & (owner == OWN_DM) & ~mem_wr), .d(mem_rdata), .q(dm_rdata)
    );

    dff1 u_if_done (.clk(clk), .rst(rst), .en(1'b1), .d(fin & (owner == OWN_IF)), .q(if_done));
    dff1 u_dm_done (.clk(clk), .rst(rst), .en(1'b1), .d(fin & (owner == OWN_DM)), .q(dm_done));

    assign stall_if  = if_req & ~if_done;
    assign stall_mem = dm_req & ~dm_done;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized bench against a timestamp-based transaction model
module tb_mem_port_arbiter;

    localparam int L = 4;

    logic        clk, rst;
    logic        if_req, dm_req, dm_wr;
    logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_done, dm_done, mem_en, mem_wr, stall_if, stall_mem, busy;

    mem_port_arbiter #(.MEM_LAT(L), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0;

    // model: one access at a time, described by its grant cycle g
    bit          act, own_dm, own_wr, last_dm, post_rst = 1'b1;
    int          g;
    logic [15:0] own_addr, own_wdata, e_if_rd, e_dm_rd;
    bit          if_done_q, dm_done_q, if_pend, dm_pend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic step();
        logic [15:0] rd;
        bit ifd, dmd;
        rd = 16'($urandom);
        mem_rdata = rd;
        #1;
        ifd = act && cyc == g + 2 + L && !own_dm;
        dmd = act && cyc == g + 2 + L && own_dm;
        chk("mem_en", 32'(mem_en), 32'(act && cyc == g + 1));
        chk("if_done", 32'(if_done), 32'(ifd));
        chk("dm_done", 32'(dm_done), 32'(dmd));
        chk("busy", 32'(busy), 32'(act && cyc > g));
        chk("if_rdata", 32'(if_rdata), 32'(e_if_rd));
        chk("dm_rdata", 32'(dm_rdata), 32'(e_dm_rd));
        chk("stall_if", 32'(stall_if), 32'(if_req && !ifd));
        chk("stall_mem", 32'(stall_mem), 32'(dm_req && !dmd));
        if (act && cyc > g && cyc <= g + 1 + L) begin
            chk("mem_addr", 32'(mem_addr), 32'(own_addr));
            chk("mem_wr", 32'(mem_wr), 32'(own_wr));
            chk("mem_wdata", 32'(mem_wdata), 32'(own_wdata));
        end
        if (post_rst) begin
            chk("rst_addr", 32'(mem_addr), 32'h0);
            chk("rst_wr", 32'(mem_wr), 32'h0);
            chk("rst_wdata", 32'(mem_wdata), 32'h0);
        end
        if_done_q = ifd;
        dm_done_q = dmd;
        post_rst  = 1'b0;
        if (!rst) begin
            act = 1'b0; last_dm = 1'b0; e_if_rd = '0; e_dm_rd = '0; post_rst = 1'b1;
        end else if (act && cyc == g + 1 + L) begin
            if (!own_dm) e_if_rd = rd;
            else if (!own_wr) e_dm_rd = rd;
        end else if (act && cyc == g + 2 + L) begin
            act = 1'b0;
        end else if (!act && (if_req || dm_req)) begin
            own_dm    = dm_req && (!if_req || !last_dm);
            last_dm   = own_dm;
            act       = 1'b1;
            g         = cyc;
            own_addr  = own_dm ? dm_addr : if_addr;
            own_wr    = own_dm && dm_wr;
            own_wdata = own_dm ? dm_wdata : 16'h0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic update_reqs(input bit rnd);
        if (if_pend && if_done_q) begin if_pend = 0; if_req = 0; end
        if (dm_pend && dm_done_q) begin dm_pend = 0; dm_req = 0; end
        if (rnd) begin
            if (if_pend && act && !own_dm && cyc > g) begin
                if ($urandom_range(0, 7) == 0) if_req = 0;
                if ($urandom_range(0, 3) == 0) if_addr = 16'($urandom);
            end
            if (dm_pend && act && own_dm && cyc > g) begin
                if ($urandom_range(0, 7) == 0) dm_req = 0;
                if ($urandom_range(0, 3) == 0) begin dm_addr = 16'($urandom); dm_wdata = 16'($urandom); end
            end
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1; if_req = 1; if_addr = 16'($urandom);
            end
            if (!dm_pend && $urandom_range(0, 2) == 0) begin
                dm_pend = 1; dm_req = 1; dm_addr = 16'($urandom);
                dm_wdata = 16'($urandom); dm_wr = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic clear_reqs();
        if_pend = 0; dm_pend = 0; if_req = 0; dm_req = 0;
    endtask

    initial begin
        int base;
        rst = 0; mem_rdata = '0; dm_wr = 0; dm_wdata = '0;
        if_req = 1; if_addr = 16'h0010; if_pend = 1;
        dm_req = 1; dm_addr = 16'h0200; dm_pend = 1;
        @(posedge clk);
        #1;
        step();
        step();
        rst = 1;
        // tie straight out of reset: data wins, fetch follows
        base = cyc;
        repeat (16) begin
            update_reqs(0);
            if (cyc - base == 6) begin
                #1;
                chk("tie_dm_done_c6", 32'(dm_done), 32'h1);
                chk("tie_stall_mem_c6", 32'(stall_mem), 32'h0);
            end
            if (cyc - base == 13) begin
                #1;
                chk("tie_if_done_c13", 32'(if_done), 32'h1);
            end
            step();
        end
        // store leaves dm_rdata alone
        dm_pend = 1; dm_req = 1; dm_wr = 1; dm_addr = 16'h0100; dm_wdata = 16'h1234;
        repeat (9) begin update_reqs(0); step(); end
        dm_wr = 0;
        // fetch dropped mid-access still completes, nothing re-issued
        if_pend = 1; if_req = 1; if_addr = 16'h0010;
        base = cyc;
        repeat (10) begin
            update_reqs(0);
            if (cyc - base == 3) if_req = 0;
            step();
        end
        // reset in the middle of an access, then a fresh fetch
        if_pend = 1; if_req = 1; if_addr = 16'h0044;
        repeat (3) begin update_reqs(0); step(); end
        rst = 0;
        step();
        rst = 1;
        clear_reqs();
        #1;
        chk("mid_rst_idle", 32'(busy), 32'h0);
        if_pend = 1; if_req = 1; if_addr = 16'h0048;
        base = cyc;
        repeat (9) begin
            update_reqs(0);
            if (cyc - base == 6) begin
                #1;
                chk("fresh_if_done_c6", 32'(if_done), 32'h1);
            end
            step();
        end
        // randomized traffic with drops, late address changes and occasional resets
        repeat (3000) begin
            update_reqs(1);
            if ($urandom_range(0, 79) == 0) rst = 0;
            step();
            if (!rst) begin rst = 1; clear_reqs(); end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
